wptr_full: RTL and testbench

Write-side pointer and full-flag controller for the dual-clock FIFO, living entirely in the write clock domain. It keeps the binary and Gray write pointers and produces the RAM write address. It brings the read side's Gray pointer across with a two-flop synchronizer and derives a registered, conservative `wfull`, a write-side occupancy count and an overflow flag. It pairs with the read-side pointer/empty logic, which consumes `graycode_wptr` through its own synchronizer.

---
 rtl/wptr_full_pkg.sv | 24 ++
 rtl/wptr_full_r2w.sv | 24 ++
 rtl/wptr_full.sv | 62 ++++++
 tb/tb_wptr_full.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wptr_full_pkg.sv
// Shared dual-clock FIFO definitions: default depth and Gray/binary conversions.
// Pure functions, no state; the read-side pointer logic reuses them.
package wptr_full_pkg;

  localparam int DEF_ADDRSIZE = 4;
  localparam int MAX_PTRW     = 32;

  typedef logic [MAX_PTRW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  // Zero-extended inputs stay correct: the leading zero bits decode to zero.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[MAX_PTRW-1] = g[MAX_PTRW-1];
    for (int i = MAX_PTRW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_r2w.sv
// Two-flop synchronizer bringing the read-side Gray pointer into the write clock.
// Two-edge latency, no backpressure; only the second stage may be consumed.
module wptr_full_r2w #(
  parameter int WIDTH = 5
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] graycode_rptr,
  output logic [WIDTH-1:0] rq2
);

  logic [WIDTH-1:0] rq1;

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= graycode_rptr;
      rq2 <= rq1;
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer, registered full flag, occupancy and overflow for the async FIFO.
// Pointer/flags update one edge after an accepted write; writes while full are dropped and flagged.
module wptr_full
  import wptr_full_pkg::*;
#(
  parameter int ADDRSIZE = DEF_ADDRSIZE
) (
  input  logic                wclk,
  input  logic                rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   graycode_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   graycode_wptr,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wcount,
  output logic                werr
);

  localparam int PW = ADDRSIZE + 1;
  // Full when the write pointer leads the read pointer by one full lap: top two Gray bits inverted.
  localparam logic [ADDRSIZE:0] FULL_MASK = PW'(3) << (ADDRSIZE - 1);

  logic              wen;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] rq2;
  logic [ADDRSIZE:0] rbin_sync;

  wptr_full_r2w #(
    .WIDTH(PW)
  ) u_r2w (
    .wclk          (wclk),
    .rst           (rst),
    .graycode_rptr (graycode_rptr),
    .rq2           (rq2)
  );

  assign wen        = winc & ~wfull;
  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = PW'(bin2gray(MAX_PTRW'(wbin_next)));
  assign rbin_sync  = PW'(gray2bin(MAX_PTRW'(rq2)));

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      wbin          <= '0;
      graycode_wptr <= '0;
      wfull         <= 1'b0;
      werr          <= 1'b0;
    end else begin
      wbin          <= wbin_next;
      graycode_wptr <= wgray_next;
      wfull         <= (wgray_next == (rq2 ^ FULL_MASK));
      werr          <= winc & wfull;
    end
  end

  assign waddr  = wbin[ADDRSIZE-1:0];
  // Stale rq2 lags the real read pointer, so this can only overstate occupancy.
  assign wcount = wbin - rbin_sync;

endmodule

// File: tb/tb_wptr_full.sv
// Directed test-plan scenarios plus randomized write/read traffic against an occupancy model.
module tb_wptr_full;

  localparam int A = 4;
  localparam int D = 16;
  localparam int M = 32;

  logic         wclk = 1'b0;
  logic         rst;
  logic         winc;
  logic [A:0]   graycode_rptr;
  logic [A-1:0] waddr;
  logic [A:0]   graycode_wptr;
  logic         wfull;
  logic [A:0]   wcount;
  logic         werr;

  int checks   = 0;
  int failures = 0;
  int rb;          // true read pointer (binary), owned by the bench

  // model state: written-entry count mod M, read pointer seen 1 and 2 edges late
  int m_wbin, m_rq1, m_rq2, m_nb;
  bit m_full, m_werr, m_wen;

  wptr_full #(.ADDRSIZE(A)) dut (
    .wclk          (wclk),
    .rst           (rst),
    .winc          (winc),
    .graycode_rptr (graycode_rptr),
    .waddr         (waddr),
    .graycode_wptr (graycode_wptr),
    .wfull         (wfull),
    .wcount        (wcount),
    .werr          (werr)
  );

  always #5 wclk = ~wclk;

  assign graycode_rptr = (A+1)'(rb ^ (rb >> 1));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
    end
  endtask

  always_comb begin
    m_wen = winc && !m_full;
    m_nb  = (m_wbin + (m_wen ? 1 : 0)) % M;
  end

  always @(posedge wclk or posedge rst) begin
    if (rst) begin
      m_wbin <= 0;
      m_rq1  <= 0;
      m_rq2  <= 0;
      m_full <= 0;
      m_werr <= 0;
    end else begin
      m_wbin <= m_nb;
      m_full <= ((m_nb - m_rq2 + M) % M) == D;
      m_werr <= winc && m_full;
      m_rq1  <= rb;
      m_rq2  <= m_rq1;
    end
  end

  always @(negedge wclk) begin
    chk("waddr",  waddr,         m_wbin % D);
    chk("gptr",   graycode_wptr, m_wbin ^ (m_wbin >> 1));
    chk("wfull",  wfull,         m_full);
    chk("wcount", wcount,        (m_wbin - m_rq2 + M) % M);
    chk("werr",   werr,          m_werr);
  end

  task automatic step();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    rb   = 0;
    winc = 1'b0;
    @(negedge wclk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "_waddr"},  waddr,         0);
    chk({n, "_gptr"},   graycode_wptr, 0);
    chk({n, "_wfull"},  wfull,         0);
    chk({n, "_wcount"}, wcount,        0);
    chk({n, "_werr"},   werr,          0);
  endtask

  initial begin
    int rdp;
    rst  = 1'b0;
    winc = 1'b0;
    rb   = 0;

    // reset asserted between edges takes effect immediately
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_async");
    @(negedge wclk);
    rst  = 1'b0;
    winc = 1'b1;
    step();
    winc = 1'b0;
    chk("first_waddr",  waddr,         1);
    chk("first_gptr",   graycode_wptr, 5'b00001);
    chk("first_wcount", wcount,        1);

    // fill to depth
    do_reset();
    winc = 1'b1;
    repeat (16) step();
    chk("fill_wfull",  wfull,         1);
    chk("fill_waddr",  waddr,         0);
    chk("fill_gptr",   graycode_wptr, 5'b11000);
    chk("fill_wcount", wcount,        16);

    // overflow: rejected writes flagged one edge later, pointer frozen
    repeat (3) begin
      step();
      chk("ovf_werr", werr,          1);
      chk("ovf_gptr", graycode_wptr, 5'b11000);
    end
    winc = 1'b0;
    step();
    chk("ovf_werr_clear", werr, 0);

    // release: one read becomes visible after 2 edges (count) and 3 edges (full)
    rb = 1;
    step();
    chk("rel1_wcount", wcount, 16);
    chk("rel1_wfull",  wfull,  1);
    step();
    chk("rel2_wcount", wcount, 15);
    chk("rel2_wfull",  wfull,  1);
    step();
    chk("rel3_wfull",  wfull,  0);
    winc = 1'b1;
    step();
    winc = 1'b0;
    chk("rel_write_gptr", graycode_wptr, 5'b11001);
    chk("rel_write_full", wfull,         1);

    // wrap with the reader trailing by two entries
    do_reset();
    winc = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      rb = (i - 1 >= 2) ? ((i - 3) % M) : 0;
      step();
      chk("wrap_wfull", wfull, 0);
      chk("wrap_werr",  werr,  0);
      if (i == 31) chk("wrap_gptr31", graycode_wptr, 5'b10000);
      if (i == 32) begin
        chk("wrap_gptr32",  graycode_wptr, 5'b00000);
        chk("wrap_waddr32", waddr,         0);
      end
    end
    winc = 1'b0;

    // mid-burst reset
    do_reset();
    winc = 1'b1;
    repeat (9) step();
    #1 rst = 1'b1;
    rb   = 0;
    winc = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge wclk);
    rst = 1'b0;
    chk("post_rst_waddr", waddr, 0);
    winc = 1'b1;
    step();
    winc = 1'b0;
    chk("post_rst_waddr1", waddr, 1);

    // randomized traffic with varying read pressure
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      rdp = (ph == 0) ? 15 : (ph == 1) ? 50 : (ph == 2) ? 85 : 35;
      repeat (500) begin
        winc = ($urandom_range(0, 99) < 65);
        if (((m_wbin - rb + M) % M) > 0 && $urandom_range(0, 99) < rdp)
          rb = (rb + 1) % M;
        step();
      end
    end
    winc = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
